instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_if.sv | 13 +
 rtl/fetch_queue.sv | 60 ++++++
 rtl/instr_fetch.sv | 129 ++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared CPU defines for the instruction fetch unit: EIP register command codes,
// fetch FSM encodings, widths and the memory beat payload handed to the byte queue.
package instr_fetch_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned QBYTES  = 8;
    localparam int unsigned QCNT_W  = 4;
    localparam int unsigned EIPRW_W = 4;

    localparam logic [EIPRW_W-1:0] EIP_RW_WRITE = 4'h4;
    localparam logic [EIPRW_W-1:0] EIP_RW_NOP   = 4'h0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // One acknowledged memory word plus the number of leading bytes to discard.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        skip;
    } fetch_beat_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: request/address out, one-cycle ack with data back.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input  mem_ack, input  mem_rdata);
    modport slave  (input  mem_req, input  mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/fetch_queue.sv
// 8-byte instruction byte queue: drops consumed bytes from the front and appends
// the useful bytes of a memory beat behind whatever remains, in the same cycle.
module fetch_queue
    import instr_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  consume_en,
    input  logic [QCNT_W-1:0]     consume_len,
    input  logic                  append_en,
    input  fetch_beat_t           append_beat,
    output logic [QCNT_W-1:0]     q_count,
    output logic [8*QBYTES-1:0]   q_bytes
);

    localparam int unsigned QW = 8 * QBYTES;

    logic [QW-1:0]     data_q, data_d;
    logic [QW-1:0]     shifted, appended;
    logic [QCNT_W-1:0] count_q, count_d;
    logic [QCNT_W-1:0] kept, app_cnt;
    logic [DATA_W-1:0] beat_bytes;

    // Bytes above count_q are kept at zero, so shifts alone preserve that invariant.
    always_comb begin
        shifted    = data_q;
        kept       = count_q;
        if (consume_en) begin
            shifted = data_q >> {consume_len, 3'b000};
            kept    = count_q - consume_len;
        end
        beat_bytes = append_beat.data >> {append_beat.skip, 3'b000};
        app_cnt    = QCNT_W'(4) - QCNT_W'(append_beat.skip);
        appended   = QW'(beat_bytes) << {kept, 3'b000};
        data_d     = shifted;
        count_d    = kept;
        if (clear) begin
            data_d  = '0;
            count_d = '0;
        end else if (append_en) begin
            data_d  = shifted | appended;
            count_d = kept + app_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign q_count = count_q;
    assign q_bytes = data_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: keeps the byte queue topped up from word-aligned memory reads,
// retires decoded bytes and redirects on flush, issuing EIP register writes for both.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_EIP = 32'h0000_0000
) (
    input  logic                  clock_5,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     eip,
    instr_fetch_if.master         mem,
    output logic [QCNT_W-1:0]     q_count,
    output logic [8*QBYTES-1:0]   q_bytes,
    input  logic                  consume,
    input  logic [QCNT_W-1:0]     consume_len,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     flush_target,
    output logic [EIPRW_W-1:0]    eip_rw,
    output logic [ADDR_W-1:0]     eip_wdata
);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
    logic [1:0]         skip_q, skip_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [EIPRW_W-1:0] eip_rw_q, eip_rw_d;
    logic [ADDR_W-1:0]  eip_wdata_q, eip_wdata_d;

    logic               consume_ok;
    logic               append_en;
    fetch_beat_t        beat;

    assign consume_ok = consume && (consume_len != '0) && (consume_len <= q_count) && !flush;
    assign append_en  = (state_q == ST_BUSY) && mem.mem_ack && !flush;
    assign beat       = '{data: mem.mem_rdata, skip: skip_q};

    // Next-state, address and EIP command logic; flush overrides consume and ack data.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        skip_d       = skip_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        eip_rw_d     = EIP_RW_NOP;
        eip_wdata_d  = eip_wdata_q;

        if (flush) begin
            fetch_addr_d = {flush_target[ADDR_W-1:2], 2'b00};
            skip_d       = flush_target[1:0];
            eip_rw_d     = EIP_RW_WRITE;
            eip_wdata_d  = flush_target;
        end else if (consume_ok) begin
            eip_rw_d     = EIP_RW_WRITE;
            eip_wdata_d  = eip + ADDR_W'(consume_len);
        end

        case (state_q)
            ST_IDLE: begin
                if (!flush && (q_count <= QCNT_W'(4))) begin
                    state_d    = ST_BUSY;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_addr_q;
                end
            end
            ST_BUSY: begin
                if (mem.mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (!flush) begin
                        fetch_addr_d = fetch_addr_q + ADDR_W'(4);
                        skip_d       = 2'b00;
                    end
                end else if (flush) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                // The stale response is swallowed; the redirect target is already latched.
                if (mem.mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_5) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= {RESET_EIP[ADDR_W-1:2], 2'b00};
            skip_q       <= RESET_EIP[1:0];
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            eip_rw_q     <= EIP_RW_NOP;
            eip_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            skip_q       <= skip_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            eip_rw_q     <= eip_rw_d;
            eip_wdata_q  <= eip_wdata_d;
        end
    end

    fetch_queue u_queue (
        .clk         (clock_5),
        .reset       (reset),
        .clear       (flush),
        .consume_en  (consume_ok),
        .consume_len (consume_len),
        .append_en   (append_en),
        .append_beat (beat),
        .q_count     (q_count),
        .q_bytes     (q_bytes)
    );

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign eip_rw       = eip_rw_q;
    assign eip_wdata    = eip_wdata_q;

endmodule
